// File: rtl/vsim_cycle_mon_pkg.sv
// Shared definitions for the vsim cycle monitor: state encoding, register map, address width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vsim_cycle_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Register map: LIMIT, WDOG, then START/STOP pairs per window
  localparam int LIMIT_ADDR = 0;
  localparam int WDOG_ADDR  = 1;
  localparam int WIN_BASE   = 2;

  // Config address width needed to reach every window register
  function automatic int calc_aw(input int num_win);
    return $clog2(WIN_BASE + 2 * num_win);
  endfunction

endpackage

// File: rtl/vsim_win_cmp.sv
// One capture window: START/STOP registers plus a registered START <= count < STOP compare.
// Latency: win_active follows the compare by one cycle; a config write is used the cycle after it lands.
// Backpressure: none; config writes are always accepted.
module vsim_win_cmp
  import vsim_cycle_mon_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int AW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic [CNT_W-1:0] cycle_count,
  input  logic             open_ok,
  output logic             win_active
);

  localparam logic [AW-1:0] START_ADDR = AW'(WIN_BASE + 2 * IDX);
  localparam logic [AW-1:0] STOP_ADDR  = AW'(WIN_BASE + 2 * IDX + 1);

  logic [CNT_W-1:0] start_q;
  logic [CNT_W-1:0] stop_q;

  // Window bounds; all-ones reset makes START >= STOP so the window stays shut
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= '1;
      stop_q  <= '1;
    end else if (cfg_we) begin
      if (cfg_addr == START_ADDR) start_q <= cfg_wdata;
      if (cfg_addr == STOP_ADDR)  stop_q  <= cfg_wdata;
    end
  end

  // Registered range compare; open_ok drops in HALT so the window closes a cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      win_active <= 1'b0;
    end else begin
      win_active <= open_ok && (start_q <= cycle_count) && (cycle_count < stop_q);
    end
  end

endmodule

// File: rtl/vsim_cycle_mon.sv
// Cycle monitor: run/pause/halt FSM, saturating cycle counter, limit and watchdog halts, capture windows.
// Latency: a halt condition in cycle N shows as HALT/done/sticky flag after edge N+1; windows lag the count by one.
// Backpressure: none; config writes are accepted in every state and counting follows run directly.
module vsim_cycle_mon
  import vsim_cycle_mon_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_WIN = 4,
  parameter int WDOG_W  = 16,
  parameter int AW      = calc_aw(NUM_WIN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               activity,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CNT_W-1:0]   cfg_wdata,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [NUM_WIN-1:0] win_active,
  output logic               limit_hit,
  output logic               wdog_hit,
  output logic               done,
  output logic [1:0]         state
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WDOG_W-1:0] IDLE_MAX = {WDOG_W{1'b1}};

  state_t            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  limit_q;
  logic [WDOG_W-1:0] idle_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              lim_cond;
  logic              wd_cond;
  logic              halt_go;
  logic              open_ok;

  // Compares use ">=" so a limit written at or below the current count still halts
  assign lim_cond = (limit_q != '0) && (cnt_q >= limit_q);
  assign wd_cond  = (wdog_q != '0) && (idle_q >= wdog_q);
  assign halt_go  = (st_q == ST_RUN) && (lim_cond || wd_cond);
  assign open_ok  = (st_q == ST_RUN) || (st_q == ST_PAUSE);

  // Next-state: halt takes priority over pause; HALT only leaves through reset
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (run) st_d = ST_RUN;
      ST_RUN: begin
        if (halt_go)   st_d = ST_HALT;
        else if (!run) st_d = ST_PAUSE;
      end
      ST_PAUSE: if (run) st_d = ST_RUN;
      ST_HALT:  st_d = ST_HALT;
      default:  st_d = ST_IDLE;
    endcase
  end

  // State register, one-cycle done pulse and sticky halt causes
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      done      <= 1'b0;
      limit_hit <= 1'b0;
      wdog_hit  <= 1'b0;
    end else begin
      st_q      <= st_d;
      done      <= halt_go;
      limit_hit <= limit_hit | (halt_go & lim_cond);
      wdog_hit  <= wdog_hit  | (halt_go & wd_cond);
    end
  end

  // Limit and watchdog config registers; other addresses belong to windows or are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      limit_q <= '0;
      wdog_q  <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == AW'(LIMIT_ADDR)) limit_q <= cfg_wdata;
      if (cfg_addr == AW'(WDOG_ADDR))  wdog_q  <= WDOG_W'(cfg_wdata);
    end
  end

  // Counters advance only in RUN; the halting cycle does not advance so the count holds at the limit
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      idle_q <= '0;
    end else if ((st_q == ST_RUN) && !halt_go) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (activity)               idle_q <= '0;
      else if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    vsim_win_cmp #(
      .CNT_W(CNT_W),
      .AW   (AW),
      .IDX  (i)
    ) u_win (
      .clock      (clock),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cycle_count(cnt_q),
      .open_ok    (open_ok),
      .win_active (win_active[i])
    );
  end

  assign cycle_count = cnt_q;
  assign state       = st_q;

endmodule

// File: tb/tb_vsim_cycle_mon.sv
// Bench for vsim_cycle_mon: directed stimulus pushes expected outputs, a negedge monitor compares.
// Latency: expectations are stamped with the cycle they apply to.
// Backpressure: n/a.
module tb_vsim_cycle_mon;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic        clock = 1'b0;
  logic        reset, run, activity, cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cycle_count;
  logic [3:0]  win_active;
  logic        limit_hit, wdog_hit, done;
  logic [1:0]  state;

  typedef struct {
    int          at;
    int          tag;
    logic [31:0] cnt;
    logic [3:0]  win;
    logic        lim;
    logic        wd;
    logic        dn;
    logic [1:0]  st;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  vsim_cycle_mon #(.CNT_W(32), .NUM_WIN(4), .WDOG_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .activity   (activity),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cycle_count(cycle_count),
    .win_active (win_active),
    .limit_hit  (limit_hit),
    .wdog_hit   (wdog_hit),
    .done       (done),
    .state      (state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare any expectation stamped for this cycle at the falling edge
  always @(negedge clock) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at < cyc) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_expect tag=%0d at=%0d now=%0d", e.tag, e.at, cyc);
    end
    if (sbq.size() > 0 && sbq[0].at == cyc) begin
      e = sbq.pop_front();
      checks++;
      if (cycle_count !== e.cnt || win_active !== e.win || limit_hit !== e.lim ||
          wdog_hit !== e.wd || done !== e.dn || state !== e.st) begin
        errors++;
        $display("FAIL test%0d cyc=%0d got cnt=%0d win=%b lim=%b wd=%b done=%b st=%0d expected cnt=%0d win=%b lim=%b wd=%b done=%b st=%0d",
                 e.tag, cyc, cycle_count, win_active, limit_hit, wdog_hit, done, state,
                 e.cnt, e.win, e.lim, e.wd, e.dn, e.st);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_now(input int tag, input logic [31:0] c, input logic [3:0] w,
                            input logic l, input logic wd, input logic dn, input logic [1:0] st);
    exp_t e;
    e.at = cyc; e.tag = tag; e.cnt = c; e.win = w;
    e.lim = l; e.wd = wd; e.dn = dn; e.st = st;
    sbq.push_back(e);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset(input int tag);
    reset = 1'b1; run = 1'b0; activity = 1'b0; cfg_we = 1'b0;
    step(); expect_now(tag, 0, 4'b0, 0, 0, 0, IDLE);
    step(); expect_now(tag, 0, 4'b0, 0, 0, 0, IDLE);
    reset = 1'b0;
    step(); expect_now(tag, 0, 4'b0, 0, 0, 0, IDLE);
  endtask

  // Window-0 expectations with a 6-cycle pause around count 7
  int         p_cnt[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 7, 7, 8, 9, 10};
  logic [1:0] p_st[17]  = '{RUN, RUN, RUN, RUN, RUN, RUN, RUN,
                            PAUSE, PAUSE, PAUSE, PAUSE, PAUSE, PAUSE,
                            RUN, RUN, RUN, RUN};
  logic       p_w0[17]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    reset = 1'b1; run = 1'b0; activity = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Test 1: LIMIT=10, count 0..10 then HALT with a single done pulse
    do_reset(1);
    cfg(4'd0, 32'd10);
    expect_now(1, 0, 4'b0, 0, 0, 0, IDLE);
    run = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step(); expect_now(1, k, 4'b0, 0, 0, 0, RUN);
    end
    step(); expect_now(1, 10, 4'b0, 1, 0, 1, HALT);
    step(); expect_now(1, 10, 4'b0, 1, 0, 0, HALT);
    step(); expect_now(1, 10, 4'b0, 1, 0, 0, HALT);

    // Test 2: WDOG=5, activity every 3rd cycle for 20 cycles, then idle
    do_reset(2);
    cfg(4'd1, 32'd5);
    run = 1'b1;
    step();
    for (int j = 0; j <= 24; j++) begin
      expect_now(2, j, 4'b0, 0, 0, 0, RUN);
      activity = (j < 20) && (j % 3 == 0);
      step();
    end
    activity = 1'b0;
    expect_now(2, 24, 4'b0, 0, 1, 1, HALT);
    step(); expect_now(2, 24, 4'b0, 0, 1, 0, HALT);

    // Test 3: WIN0 [4,8) open exactly 4 cycles, WIN1 START>STOP never opens
    do_reset(3);
    cfg(4'd2, 32'd4); cfg(4'd3, 32'd8);
    cfg(4'd4, 32'd8); cfg(4'd5, 32'd4);
    run = 1'b1;
    step();
    for (int c = 0; c <= 12; c++) begin
      expect_now(3, c, {3'b0, (c >= 5 && c <= 8)}, 0, 0, 0, RUN);
      step();
    end

    // Test 4: same windows, run dropped for 6 cycles so PAUSE holds count 7
    do_reset(4);
    cfg(4'd2, 32'd4); cfg(4'd3, 32'd8);
    cfg(4'd4, 32'd8); cfg(4'd5, 32'd4);
    run = 1'b1;
    step();
    for (int t = 0; t <= 16; t++) begin
      expect_now(4, p_cnt[t], {3'b0, p_w0[t]}, 0, 0, 0, p_st[t]);
      run = !(t >= 6 && t <= 11);
      step();
    end

    // Test 5: LIMIT=20 and WDOG=20 trip together
    do_reset(5);
    cfg(4'd0, 32'd20); cfg(4'd1, 32'd20);
    run = 1'b1; activity = 1'b0;
    step();
    for (int t = 0; t <= 20; t++) begin
      expect_now(5, t, 4'b0, 0, 0, 0, RUN);
      step();
    end
    expect_now(5, 20, 4'b0, 1, 1, 1, HALT);
    step(); expect_now(5, 20, 4'b0, 1, 1, 0, HALT);

    // Test 6: out-of-range writes ignored, LIMIT lowered below count, then reset from HALT
    do_reset(6);
    for (int a = 10; a <= 15; a++) cfg(4'(a), 32'(a - 8));
    run = 1'b1;
    step();
    for (int c = 0; c <= 50; c++) begin
      expect_now(6, c, 4'b0, 0, 0, 0, RUN);
      if (c == 50) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'd30;
      end
      step();
      cfg_we = 1'b0;
    end
    expect_now(6, 51, 4'b0, 0, 0, 0, RUN);
    step(); expect_now(6, 51, 4'b0, 1, 0, 1, HALT);
    cfg(4'd2, 32'd0); cfg(4'd3, 32'd100); cfg(4'd1, 32'd3);
    expect_now(6, 51, 4'b0, 1, 0, 0, HALT);
    do_reset(7);
    run = 1'b1; activity = 1'b0;
    step();
    for (int c = 0; c <= 35; c++) begin
      expect_now(7, c, 4'b0, 0, 0, 0, RUN);
      step();
    end

    step(); step();
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expect pending=%0d required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
